// File: rtl/ofdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_pkg
// Brief    : Shared OFDM constants, bin classification and mode encoding.
// Revision : 1.0
// ============================================================================
package ofdm_pkg;

  localparam int NFFT  = 64;
  localparam int BIN_W = 6;

  localparam logic [BIN_W-1:0] NULL_LO = 6'd27;
  localparam logic [BIN_W-1:0] NULL_HI = 6'd37;
  localparam logic [BIN_W-1:0] PILOT_0 = 6'd7;
  localparam logic [BIN_W-1:0] PILOT_1 = 6'd21;
  localparam logic [BIN_W-1:0] PILOT_2 = 6'd43;
  localparam logic [BIN_W-1:0] PILOT_3 = 6'd57;
  localparam logic [BIN_W-1:0] LAST_DATA_BIN = 6'd63;
  localparam int DATA_BINS = 48;

  // 2/sqrt(10) in Q1.14
  localparam int QAM16_THR = 10362;

  typedef enum logic {
    MOD_QPSK  = 1'b0,
    MOD_QAM16 = 1'b1
  } mod_e;

  function automatic logic bin_is_null(input logic [BIN_W-1:0] idx);
    return (idx == '0) || ((idx >= NULL_LO) && (idx <= NULL_HI));
  endfunction

  function automatic logic bin_is_pilot(input logic [BIN_W-1:0] idx);
    return (idx == PILOT_0) || (idx == PILOT_1) ||
           (idx == PILOT_2) || (idx == PILOT_3);
  endfunction

  function automatic logic bin_is_data(input logic [BIN_W-1:0] idx);
    return !(bin_is_null(idx) || bin_is_pilot(idx));
  endfunction

endpackage
`default_nettype wire

// File: rtl/qam_slicer.sv
`default_nettype none
// ============================================================================
// Module   : qam_slicer
// Brief    : Combinational hard slicer, QPSK or 16-QAM Gray bits per sample.
// Revision : 1.0
// ============================================================================
module qam_slicer
  import ofdm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int THR    = 10362
) (
  input  logic signed [DATA_W-1:0] re,
  input  logic signed [DATA_W-1:0] im,
  input  mod_e                     mode,
  output logic        [3:0]        bits
);

  localparam logic [DATA_W:0] c_thr = (DATA_W+1)'(THR);

  logic signed [DATA_W:0] w_re_x;
  logic signed [DATA_W:0] w_im_x;
  logic        [DATA_W:0] w_re_abs;
  logic        [DATA_W:0] w_im_abs;
  logic                   w_re_sign;
  logic                   w_im_sign;
  logic                   w_re_inner;
  logic                   w_im_inner;

  // One extra bit so that the most negative code has a representable magnitude
  assign w_re_x   = {re[DATA_W-1], re};
  assign w_im_x   = {im[DATA_W-1], im};
  assign w_re_abs = re[DATA_W-1] ? unsigned'(-w_re_x) : unsigned'(w_re_x);
  assign w_im_abs = im[DATA_W-1] ? unsigned'(-w_im_x) : unsigned'(w_im_x);

  assign w_re_sign  = ~re[DATA_W-1];
  assign w_im_sign  = ~im[DATA_W-1];
  assign w_re_inner = (w_re_abs < c_thr);
  assign w_im_inner = (w_im_abs < c_thr);

  always_comb begin
    bits = 4'b0000;
    case (mode)
      MOD_QAM16: bits = {w_im_inner, w_im_sign, w_re_inner, w_re_sign};
      default:   bits = {2'b00, w_im_sign, w_re_sign};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ofdm_qam_demapper.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_qam_demapper
// Brief    : Drops null/pilot bins, slices both streams, packs bits to bytes.
// Revision : 1.0
// ============================================================================
module ofdm_qam_demapper #(
  parameter int DATA_W    = 16,
  parameter int NFFT      = ofdm_pkg::NFFT,
  parameter int QAM16_THR = ofdm_pkg::QAM16_THR
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] X1_re,
  input  logic signed [DATA_W-1:0] X1_im,
  input  logic signed [DATA_W-1:0] X2_re,
  input  logic signed [DATA_W-1:0] X2_im,
  input  logic                     mod_sel,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic [5:0]               bin_idx
);

  import ofdm_pkg::*;

  localparam logic [BIN_W-1:0] c_last_bin = BIN_W'(NFFT - 1);

  logic [BIN_W-1:0] r_bin;
  mod_e             r_mode;
  logic [3:0]       r_half;
  logic             r_half_full;

  mod_e             w_mode;
  logic             w_is_data;
  logic             w_is_last;
  logic [3:0]       w_nibble;
  logic [3:0]       w_bits [2];
  logic [DATA_W-1:0] w_re  [2];
  logic [DATA_W-1:0] w_im  [2];

  assign w_re[0] = X1_re;
  assign w_im[0] = X1_im;
  assign w_re[1] = X2_re;
  assign w_im[1] = X2_im;

  generate
    for (genvar s = 0; s < 2; s++) begin : g_slicer
      qam_slicer #(
        .DATA_W (DATA_W),
        .THR    (QAM16_THR)
      ) u_slicer (
        .re   (w_re[s]),
        .im   (w_im[s]),
        .mode (w_mode),
        .bits (w_bits[s])
      );
    end
  endgenerate

  // The live mod_sel applies on bin 0 itself; later bins use the latched copy
  assign w_mode    = (r_bin == '0) ? mod_e'(mod_sel) : r_mode;
  assign w_is_data = bin_is_data(r_bin);
  assign w_is_last = (r_bin == c_last_bin);
  assign w_nibble  = {w_bits[1][1:0], w_bits[0][1:0]};
  assign bin_idx   = r_bin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin       <= '0;
      r_mode      <= MOD_QPSK;
      r_half      <= '0;
      r_half_full <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        r_bin <= w_is_last ? '0 : r_bin + 1'b1;

        // Bin 0 is null, so this clear never races a data beat
        if (r_bin == '0) begin
          r_mode      <= w_mode;
          r_half      <= '0;
          r_half_full <= 1'b0;
        end

        if (w_is_data) begin
          if (w_mode == MOD_QAM16) begin
            out_valid <= 1'b1;
            out_data  <= {w_bits[1], w_bits[0]};
            out_last  <= w_is_last;
          end else if (r_half_full) begin
            out_valid   <= 1'b1;
            out_data    <= {w_nibble, r_half};
            out_last    <= w_is_last;
            r_half_full <= 1'b0;
          end else begin
            r_half      <= w_nibble;
            r_half_full <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofdm_qam_demapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofdm_qam_demapper
// Brief    : Directed self-checking bench for ofdm_qam_demapper.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ofdm_qam_demapper;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] X1_re, X1_im, X2_re, X2_im;
  logic               mod_sel;
  logic               out_valid;
  logic [7:0]         out_data;
  logic               out_last;
  logic [5:0]         bin_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] cap [$];

  always #5 clk = ~clk;

  ofdm_qam_demapper #(
    .DATA_W    (16),
    .NFFT      (64),
    .QAM16_THR (10362)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .X1_re     (X1_re),
    .X1_im     (X1_im),
    .X2_re     (X2_re),
    .X2_im     (X2_im),
    .mod_sel   (mod_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .bin_idx   (bin_idx)
  );

  always @(negedge clk)
    if (rst_n && out_valid) cap.push_back({out_last, out_data});

  function automatic logic tb_is_data(input int b);
    if (b == 0 || (b >= 27 && b <= 37)) return 1'b0;
    if (b == 7 || b == 21 || b == 43 || b == 57) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_data(input int scen, input int b);
    case (scen)
      0: begin X1_re = 12000; X1_im = -3000; X2_re = -3000; X2_im = 12000; end
      1: begin X1_re = 100;   X1_im = 100;   X2_re = 100;   X2_im = 100;   end
      2: begin X1_re = -100;  X1_im = 100;   X2_re = 100;   X2_im = -100;  end
      default: begin
        if (tb_is_data(b)) begin
          X1_re = -32768; X1_im = 10362; X2_re = 10361; X2_im = -1;
        end else begin
          X1_re = -32768; X1_im = -32768; X2_re = -32768; X2_im = -32768;
        end
      end
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Gap mode inserts 3 idle cycles after bins 10, 30 and 63 and checks them
  task automatic send_sym(input int scen, input logic mode, input int toggle_bin,
                          input int max_beats, input logic gaps);
    for (int b = 0; b < max_beats; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      mod_sel  = (b >= toggle_bin) ? ~mode : mode;
      set_data(scen, b);
      if (gaps && (b == 10 || b == 30 || b == 63)) begin
        for (int g = 1; g <= 3; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          n_tests++;
          if (bin_idx !== 6'((b + 1) % 64)) begin
            n_fail++;
            $display("FAIL gap_bin_idx b=%0d g=%0d: got %0d expected %0d", b, g, bin_idx, (b + 1) % 64);
          end
          n_tests++;
          if (out_valid !== ((g == 1) && tb_is_data(b))) begin
            n_fail++;
            $display("FAIL gap_out_valid b=%0d g=%0d: got %b expected %b", b, g, out_valid, (g == 1) && tb_is_data(b));
          end
          n_tests++;
          if (out_data !== 8'h69 || out_last !== (b == 63)) begin
            n_fail++;
            $display("FAIL gap_hold b=%0d g=%0d: got %b/%h expected %b/69", b, g, out_last, out_data, b == 63);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; mod_sel = 1'b0;
    X1_re = 0; X1_im = 0; X2_re = 0; X2_im = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || bin_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b d=%h l=%b bin=%0d expected 0/00/0/0", out_valid, out_data, out_last, bin_idx);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_qam16_const();
    cap.delete();
    send_sym(0, 1'b1, 64, 64, 1'b0);
    idle(3);
    n_tests++;
    if (cap.size() !== 48) begin
      n_fail++;
      $display("FAIL qam16_count: got %0d expected 48", cap.size());
    end
    foreach (cap[i]) begin
      n_tests++;
      if (cap[i] !== {(i == 47), 8'h69}) begin
        n_fail++;
        $display("FAIL qam16_byte[%0d]: got %h expected %h", i, cap[i], {(i == 47), 8'h69});
      end
    end
  endtask

  task automatic test_qpsk_const();
    cap.delete();
    send_sym(1, 1'b0, 64, 64, 1'b0);
    send_sym(2, 1'b0, 64, 64, 1'b0);
    idle(3);
    n_tests++;
    if (cap.size() !== 48) begin
      n_fail++;
      $display("FAIL qpsk_count: got %0d expected 48", cap.size());
    end
    foreach (cap[i]) begin
      n_tests++;
      if (cap[i] !== {(i == 23 || i == 47), (i < 24) ? 8'hFF : 8'h66}) begin
        n_fail++;
        $display("FAIL qpsk_byte[%0d]: got %h expected %h", i, cap[i], {(i == 23 || i == 47), (i < 24) ? 8'hFF : 8'h66});
      end
    end
  endtask

  // X1=(-32768,10362) -> 0100, X2=(10361,-1) -> 1011 under the slicing rules
  task automatic test_saturation();
    cap.delete();
    send_sym(3, 1'b1, 64, 64, 1'b0);
    idle(3);
    n_tests++;
    if (cap.size() !== 48) begin
      n_fail++;
      $display("FAIL sat_count: got %0d expected 48", cap.size());
    end
    foreach (cap[i]) begin
      n_tests++;
      if (cap[i] !== {(i == 47), 8'hB4}) begin
        n_fail++;
        $display("FAIL sat_byte[%0d]: got %h expected %h", i, cap[i], {(i == 47), 8'hB4});
      end
    end
  endtask

  task automatic test_gaps();
    cap.delete();
    send_sym(0, 1'b1, 64, 64, 1'b1);
    idle(3);
    n_tests++;
    if (cap.size() !== 48) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d expected 48", cap.size());
    end
    foreach (cap[i]) begin
      n_tests++;
      if (cap[i] !== {(i == 47), 8'h69}) begin
        n_fail++;
        $display("FAIL gaps_byte[%0d]: got %h expected %h", i, cap[i], {(i == 47), 8'h69});
      end
    end
  endtask

  // Back-to-back: QPSK symbol with a mid-symbol mod_sel flip, then 16-QAM
  task automatic test_back_to_back();
    cap.delete();
    send_sym(1, 1'b0, 20, 64, 1'b0);
    send_sym(1, 1'b1, 64, 64, 1'b0);
    idle(3);
    n_tests++;
    if (cap.size() !== 72) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 72", cap.size());
    end
    foreach (cap[i]) begin
      n_tests++;
      if (cap[i] !== {(i == 23 || i == 71), 8'hFF}) begin
        n_fail++;
        $display("FAIL b2b_byte[%0d]: got %h expected %h", i, cap[i], {(i == 23 || i == 71), 8'hFF});
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    cap.delete();
    send_sym(1, 1'b0, 64, 30, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (cap.size() !== 12) begin
      n_fail++;
      $display("FAIL pre_reset_count: got %0d expected 12", cap.size());
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || bin_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset_values: got v=%b d=%h l=%b bin=%0d expected 0/00/0/0", out_valid, out_data, out_last, bin_idx);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    send_sym(2, 1'b0, 64, 64, 1'b0);
    idle(3);
    n_tests++;
    if (cap.size() !== 24) begin
      n_fail++;
      $display("FAIL post_reset_count: got %0d expected 24", cap.size());
    end
    foreach (cap[i]) begin
      n_tests++;
      if (cap[i] !== {(i == 23), 8'h66}) begin
        n_fail++;
        $display("FAIL post_reset_byte[%0d]: got %h expected %h", i, cap[i], {(i == 23), 8'h66});
      end
    end
  endtask

  initial begin
    test_reset();
    test_qam16_const();
    test_qpsk_const();
    test_saturation();
    test_gaps();
    test_back_to_back();
    test_reset_mid_symbol();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
